// File: rtl/camera_i2c_pkg.sv
// Shared types for the camera-sensor I2C masters: FSM states, bit-phase width,
// sensor address and the per-phase open-drain pin pattern.
package camera_i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BIT,
        ACK,
        STOP,
        DONE
    } i2c_state_t;

    localparam int PHASE_W = 2;
    localparam logic [7:0] SENSOR_ADDR = 8'hBA;

    // Returns {scl_low, sda_low}; a 1 pulls the line to 0, a 0 releases it.
    function automatic logic [1:0] bus_drive(input i2c_state_t st,
                                             input logic [PHASE_W-1:0] ph,
                                             input logic msb);
        logic [1:0] d;
        d = 2'b00;
        case (st)
            START: begin
                case (ph)
                    2'd0:      d = 2'b00;
                    2'd1, 2'd2: d = 2'b01;
                    default:   d = 2'b11;
                endcase
            end
            BIT:  d = {(ph == 2'd0) || (ph == 2'd3), ~msb};
            ACK:  d = {(ph == 2'd0) || (ph == 2'd3), 1'b0};
            STOP: begin
                case (ph)
                    2'd0:    d = 2'b11;
                    2'd1:    d = 2'b01;
                    default: d = 2'b00;
                endcase
            end
            default: d = 2'b00;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-SCL-period clock enable: one tick every TICK_DIV cycles while run=1.
// Latency: first tick TICK_DIV cycles after run rises; counter cleared when run=0.
// Backpressure: hold freezes the count (clock stretching) without losing position.
module i2c_tick_gen #(
    parameter int TICK_DIV = 625
) (
    input  logic clock,
    input  logic reset_n,
    input  logic run,
    input  logic hold,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (!run) begin
            cnt <= '0;
        end else if (!hold) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign tick = run && !hold && (cnt == LAST);

endmodule

// File: rtl/sccb_write_master.sv
// Single register write to the camera sensor over open-drain SCL/SDA; optional
// clock stretching via `define I2C_CLOCK_STRETCH_EN. Latency: (9*NUM_BYTES+2)*4*TICK_DIV
// cycles go->done when ACKed. Backpressure: go is level; done holds until go drops.
module sccb_write_master
    import camera_i2c_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int I2C_FREQ  = 20000,
    parameter int NUM_BYTES = 4,
    parameter int TICK_DIV  = CLK_FREQ / (4 * I2C_FREQ)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   go,
    input  logic [8*NUM_BYTES-1:0] data,
    output logic                   busy,
    output logic                   done,
    output logic                   ack_err,
    inout  wire                    I2C_SCLK,
    inout  wire                    I2C_SDAT
);

    localparam int DW  = 8 * NUM_BYTES;
    localparam int BCW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(NUM_BYTES - 1);

    i2c_state_t         state;
    logic [PHASE_W-1:0] phase;
    logic [2:0]         bit_cnt;
    logic [BCW-1:0]     byte_cnt;
    logic [DW-1:0]      shreg;
    logic               scl_low;
    logic               sda_low;
    logic [1:0]         sda_sync;
    logic               tick;
    logic               hold;
    logic               run;

    assign run = (state == START) || (state == BIT) || (state == ACK) || (state == STOP);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) sda_sync <= 2'b11;
        else          sda_sync <= {sda_sync[0], I2C_SDAT};
    end

`ifdef I2C_CLOCK_STRETCH_EN
    logic [1:0] scl_sync;
    logic [1:0] scl_rel;
    logic       stretch_win;

    // scl_rel delays our own release to line up with the synchronizer, so only a
    // slave holding SCL low (not our own release latency) freezes the tick.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync <= 2'b11;
            scl_rel  <= 2'b00;
        end else begin
            scl_sync <= {scl_sync[0], I2C_SCLK};
            scl_rel  <= {scl_rel[0], ~scl_low};
        end
    end

    assign stretch_win = (((state == BIT) || (state == ACK)) && ((phase == 2'd1) || (phase == 2'd2)))
                       || ((state == STOP) && (phase != 2'd0));
    assign hold = stretch_win && scl_rel[1] && !scl_sync[1];
`else
    assign hold = 1'b0;
`endif

    i2c_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clock   (clock),
        .reset_n (reset_n),
        .run     (run),
        .hold    (hold),
        .tick    (tick)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            phase    <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ack_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        shreg    <= data;
                        busy     <= 1'b1;
                        ack_err  <= 1'b0;
                        phase    <= '0;
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        phase <= phase + PHASE_W'(1);
                        if (phase == 2'd3) state <= BIT;
                    end
                end
                BIT: begin
                    if (tick) begin
                        phase <= phase + PHASE_W'(1);
                        if (phase == 2'd3) begin
                            shreg   <= shreg << 1;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) state <= ACK;
                        end
                    end
                end
                ACK: begin
                    if (tick) begin
                        phase <= phase + PHASE_W'(1);
                        if ((phase == 2'd2) && sda_sync[1]) ack_err <= 1'b1;
                        if (phase == 2'd3) begin
                            // ack_err was captured on the phase-2 tick, so a NACK aborts here
                            if (ack_err || (byte_cnt == LAST_BYTE)) begin
                                state <= STOP;
                            end else begin
                                byte_cnt <= byte_cnt + BCW'(1);
                                state    <= BIT;
                            end
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        phase <= phase + PHASE_W'(1);
                        if (phase == 2'd3) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (!go) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pin pattern is registered from the current state so the pads never glitch.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) {scl_low, sda_low} <= 2'b00;
        else          {scl_low, sda_low} <= bus_drive(state, phase, shreg[DW-1]);
    end

    assign I2C_SCLK = scl_low ? 1'b0 : 1'bz;
    assign I2C_SDAT = sda_low ? 1'b0 : 1'bz;

endmodule
